// File: rtl/cache_fill_arbiter.sv
// Miss handler arbitrating I/D-cache block fills onto the shared memory read port.
// Optional ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed D-cache priority.
module cache_fill_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_miss,
  input  logic [ADDR_W-1:0]              i_miss_addr,
  input  logic                           d_miss,
  input  logic [ADDR_W-1:0]              d_miss_addr,
  output logic                           mem_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_data_valid,
  output logic                           fill_sel_d,
  output logic                           data_wen,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           tag_wen,
  output logic                           i_busy,
  output logic                           d_busy,
  output logic                           fill_done_i,
  output logic                           fill_done_d
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int CNT_W = OFF_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic                sel_d;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    tx_cnt, rx_cnt;
  logic                grant, grant_d;
  logic                rx_full, rx_last, tx_last;
  logic [ADDR_W-1:0]   grant_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = D-cache was served last

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= 1'b0;
    else if (state == DONE)
      last_grant <= sel_d;
  end

  always_comb grant_d = d_miss & (~i_miss | ~last_grant);
`else
  always_comb grant_d = d_miss;
`endif

  always_comb begin
    grant      = (state == IDLE) & (i_miss | d_miss);
    grant_addr = grant_d ? d_miss_addr : i_miss_addr;
    rx_full    = (rx_cnt == CNT_W'(BLOCK_WORDS));
    tx_last    = (tx_cnt == CNT_W'(BLOCK_WORDS - 1));
  end

  // Responses only count while a fill is in flight and the block is not yet full.
  always_comb begin
    data_wen = mem_data_valid & ((state == ISSUE) | (state == DRAIN)) & ~rx_full;
    rx_last  = rx_full | (data_wen & (rx_cnt == CNT_W'(BLOCK_WORDS - 1)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (tx_last) state_nxt = rx_last ? DONE : DRAIN;
      DRAIN:   if (rx_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel_d  <= 1'b0;
      base   <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel_d  <= grant_d;
        base   <= grant_addr & ~ADDR_W'(2 * BLOCK_WORDS - 1);
        tx_cnt <= '0;
        rx_cnt <= '0;
      end else begin
        if (state == ISSUE) tx_cnt <= tx_cnt + 1'b1;
        if (data_wen)       rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_addr    = '0;
    tag_wen     = 1'b0;
    fill_done_i = 1'b0;
    fill_done_d = 1'b0;
    case (state)
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = base | ADDR_W'({tx_cnt[OFF_W-1:0], 1'b0});
      end
      DONE: begin
        tag_wen     = 1'b1;
        fill_done_i = ~sel_d;
        fill_done_d = sel_d;
      end
      default: ;
    endcase
  end

  always_comb begin
    fill_sel_d = sel_d;
    fill_word  = rx_cnt[OFF_W-1:0];
    i_busy     = i_miss | ((state != IDLE) & ~sel_d);
    d_busy     = d_miss | ((state != IDLE) & sel_d);
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a pipelined memory of configurable latency.
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0, d_miss = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0;
  logic        mem_en, mem_data_valid;
  logic [15:0] mem_addr;
  logic        fill_sel_d, data_wen, tag_wen;
  logic [2:0]  fill_word;
  logic        i_busy, d_busy, fill_done_i, fill_done_d;

  logic [15:0] pipe = '0;
  int          lat = 4;
  logic        stray = 1'b0;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int wen_cnt = 0, tag_cnt = 0, ib_low = 0;
  int issue_cyc = 0, done_cyc = 0;
  logic [15:0] issue_addr = '0;

  cache_fill_arbiter #(.ADDR_W(16), .BLOCK_WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data_valid(mem_data_valid),
    .fill_sel_d(fill_sel_d), .data_wen(data_wen), .fill_word(fill_word),
    .tag_wen(tag_wen), .i_busy(i_busy), .d_busy(d_busy),
    .fill_done_i(fill_done_i), .fill_done_d(fill_done_d)
  );

  always #5 clk = ~clk;

  // Memory answers each request exactly lat cycles after it was issued.
  always @(posedge clk) pipe <= {pipe[14:0], mem_en};
  assign mem_data_valid = pipe[lat-1] | stray;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_mem_en"},    32'(mem_en),      0);
    check({pfx, "_mem_addr"},  32'(mem_addr),    0);
    check({pfx, "_data_wen"},  32'(data_wen),    0);
    check({pfx, "_fill_word"}, 32'(fill_word),   0);
    check({pfx, "_tag_wen"},   32'(tag_wen),     0);
    check({pfx, "_done_i"},    32'(fill_done_i), 0);
    check({pfx, "_done_d"},    32'(fill_done_d), 0);
    check({pfx, "_sel_d"},     32'(fill_sel_d),  0);
    check({pfx, "_i_busy"},    32'(i_busy),      0);
    check({pfx, "_d_busy"},    32'(d_busy),      0);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; stray = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits for the next done pulse; the served requester drops its miss at once.
  task automatic wait_done(output int is_d);
    logic prev_en;
    bit   fin;
    prev_en   = 1'b0;
    fin       = 1'b0;
    issue_cyc = -1;
    is_d      = -1;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (mem_en && !prev_en && issue_cyc < 0) begin
        issue_cyc  = cyc;
        issue_addr = mem_addr;
      end
      prev_en = mem_en;
      wen_cnt += int'(data_wen);
      tag_cnt += int'(tag_wen);
      if (!i_busy) ib_low++;
      if (fill_done_i || fill_done_d) begin
        done_cyc = cyc;
        is_d     = int'(fill_done_d);
        if (fill_done_d) d_miss = 1'b0;
        else             i_miss = 1'b0;
        fin = 1'b1;
      end
    end
    if (!fin) check("fill_timeout", 0, 1);
  endtask

  initial begin
    int g, g1, g2, dd;
    int exp_seq[3];
    bit hit;

    // Reset state
    #2;
    check_quiet("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single D miss at 0x1236, L=4, cycle-exact
    d_miss = 1'b1; d_miss_addr = 16'h1236;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("A%0d_mem_en", k), 32'(mem_en), 32'(k <= 8));
      if (k <= 8) check($sformatf("A%0d_mem_addr", k), 32'(mem_addr), 32'h1230 + 32'(2 * (k - 1)));
      check($sformatf("A%0d_data_wen", k), 32'(data_wen), 32'(k >= 5 && k <= 12));
      if (k >= 5 && k <= 12) check($sformatf("A%0d_fill_word", k), 32'(fill_word), 32'(k - 5));
      check($sformatf("A%0d_tag_wen", k), 32'(tag_wen), 32'(k == 13));
      check($sformatf("A%0d_done_d", k), 32'(fill_done_d), 32'(k == 13));
      check($sformatf("A%0d_done_i", k), 32'(fill_done_i), 0);
      check($sformatf("A%0d_sel_d", k), 32'(fill_sel_d), 1);
      check($sformatf("A%0d_d_busy", k), 32'(d_busy), 32'(k <= 13));
      if (k == 13) d_miss = 1'b0;
    end

    // Stray responses while IDLE
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stray = 1'b1;
      #1;
      check("idle_stray_wen", 32'(data_wen), 0);
      check("idle_stray_word", 32'(fill_word), 0);
    end
    @(negedge clk);
    stray = 1'b0;

    // I miss dropped during ISSUE still completes
    @(negedge clk);
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    wen_cnt = 0; tag_cnt = 0;
    repeat (3) @(negedge clk);
    i_miss = 1'b0;
    #1;
    check("drop_i_busy", 32'(i_busy), 1);
    wait_done(g);
    check("drop_target", 32'(g), 0);
    check("drop_wen_cnt", 32'(wen_cnt), 8);
    check("drop_tag_cnt", 32'(tag_cnt), 1);

    // Simultaneous misses from reset
    do_reset();
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h8000;
    ib_low = 0; wen_cnt = 0; tag_cnt = 0;
    wait_done(g1);
    check("tie_first", 32'(g1), 1);
    check("tie_first_addr", 32'(issue_addr), 32'h8000);
    check("tie_first_wen", 32'(wen_cnt), 8);
    check("tie_first_tag", 32'(tag_cnt), 1);
    dd = done_cyc;
    wen_cnt = 0; tag_cnt = 0;
    wait_done(g2);
    check("tie_second", 32'(g2), 0);
    check("tie_second_addr", 32'(issue_addr), 32'h0040);
    check("tie_issue_gap", 32'(issue_cyc - dd), 2);
    check("tie_second_wen", 32'(wen_cnt), 8);
    check("tie_i_busy_low", 32'(ib_low), 0);

    // Repeated ties
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{1, 0, 1};
`else
    exp_seq = '{1, 1, 1};
`endif
    do_reset();
    i_miss = 1'b1; d_miss = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_done(g);
      check($sformatf("rr_grant%0d", n), 32'(g), 32'(exp_seq[n]));
      i_miss = 1'b1; d_miss = 1'b1;
    end

    // Reset in DRAIN after 3 words, L=7
    do_reset();
    lat = 7;
    d_miss = 1'b1; d_miss_addr = 16'h2000;
    wen_cnt = 0; hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      wen_cnt += int'(data_wen);
      if (wen_cnt == 3 && !mem_en) hit = 1'b1;
    end
    check("mid_reach_drain", 32'(hit), 1);
    rst = 1'b1; d_miss = 1'b0;
    #1;
    check_quiet("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    wen_cnt = 0; tag_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      wen_cnt += int'(data_wen);
      tag_cnt += int'(tag_wen);
    end
    check("mid_late_wen", 32'(wen_cnt), 0);
    check("mid_late_tag", 32'(tag_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
